parity_frame_checker: RTL and testbench

PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

---
 rtl/parity_frame_checker.sv | 92 +++++++++
 tb/tb_parity_frame_checker.sv | 134 +++++++++++++
 2 files changed

// File: rtl/parity_frame_checker.sv
// parity_frame_checker: serial start/data/parity/stop frame receiver with a one-word output holding register.
// Define PARITY_ODD_EN to switch the parity check from even to odd.
module parity_frame_checker #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic              s_bit,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              par_err,
    output logic              frm_err,
    output logic              ovr_err,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t            state_q;
    logic [4:0]        cnt_q;
    logic [DATA_W-1:0] sh_q;
    logic              acc_q;
    logic              perr_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              par_q;
    logic              frm_q;
    logic              ovr_q;
    logic [DATA_W:0]   ext_d;
    logic              perr_d;
    assign ext_d = {s_bit, sh_q};
`ifdef PARITY_ODD_EN
    assign perr_d = ~(acc_q ^ s_bit);
`else
    assign perr_d = acc_q ^ s_bit;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            acc_q   <= 1'b0;
            perr_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            par_q   <= 1'b0;
            frm_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (valid_q && out_ready)
                valid_q <= 1'b0;
            if (s_valid) begin
                case (state_q)
                    IDLE: if (!s_bit) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        acc_q   <= 1'b0;
                    end
                    DATA: begin
                        sh_q  <= ext_d[DATA_W:1];
                        acc_q <= acc_q ^ s_bit;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'(DATA_W - 1))
                            state_q <= PARITY;
                    end
                    PARITY: begin
                        perr_q  <= perr_d;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        // A frame arriving while the held word is still unread is lost.
                        if (!valid_q || out_ready) begin
                            valid_q <= 1'b1;
                            data_q  <= sh_q;
                            par_q   <= perr_q;
                            frm_q   <= ~s_bit;
                        end else begin
                            ovr_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign par_err   = par_q;
    assign frm_err   = frm_q;
    assign ovr_err   = ovr_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_parity_frame_checker.sv
// tb_parity_frame_checker: directed scoreboard bench for parity_frame_checker (DATA_W=8).
module tb_parity_frame_checker;
    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_bit = 1'b1;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       par_err;
    logic       frm_err;
    logic       ovr_err;
    logic       busy;
    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    parity_frame_checker #(.DATA_W(8)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_bit(s_bit),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .par_err(par_err), .frm_err(frm_err), .ovr_err(ovr_err), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic model_perr(input logic [7:0] d, input logic p);
`ifdef PARITY_ODD_EN
        return ~(^d ^ p);
`else
        return ^d ^ p;
`endif
    endfunction
    task automatic send_bit(input logic b, input logic gap);
        s_valid = 1'b1;
        s_bit   = b;
        @(posedge clk); #1;
        if (gap) begin
            s_valid = 1'b0;
            s_bit   = ~b;
            @(posedge clk); #1;
        end
    endtask
    task automatic send(input logic [7:0] d, input logic p, input logic st, input logic gap, input logic push);
        logic [10:0] bits;
        bits = {st, p, d, 1'b0};
        if (push) sb.push_back('{data: d, perr: model_perr(d, p), ferr: ~st});
        for (int i = 0; i < 11; i++) begin
            send_bit(bits[i], gap && i < 10);
            chk($sformatf("busy_bit%0d", i), 16'(busy), 16'(i < 10));
        end
        s_valid = 1'b0;
        s_bit   = 1'b1;
    endtask
    task automatic check_out(input string tag, input logic pop);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd0, 16'd1);
            return;
        end
        e = pop ? sb.pop_front() : sb[0];
        chk({tag, "_valid"}, 16'(out_valid), 16'd1);
        chk({tag, "_data"}, 16'(out_data), 16'(e.data));
        chk({tag, "_perr"}, 16'(par_err), 16'(e.perr));
        chk({tag, "_ferr"}, 16'(frm_err), 16'(e.ferr));
    endtask
    initial begin
        #1;
        chk("rst_valid", 16'(out_valid), 16'd0);
        chk("rst_data", 16'(out_data), 16'd0);
        chk("rst_perr", 16'(par_err), 16'd0);
        chk("rst_ferr", 16'(frm_err), 16'd0);
        chk("rst_ovr", 16'(ovr_err), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
        check_out("a5_good", 1'b1);
        @(posedge clk); #1;
        chk("a5_consumed", 16'(out_valid), 16'd0);
        chk("a5_data_hold", 16'(out_data), 16'hA5);
        send(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
        check_out("a5_par1", 1'b1);
        @(posedge clk); #1;
        send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        check_out("a5_stop0", 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
        check_out("3c_held", 1'b0);
        chk("3c_no_ovr", 16'(ovr_err), 16'd0);
        send(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        check_out("ff_dropped", 1'b1);
        chk("ff_ovr", 16'(ovr_err), 16'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("ovr_drain_valid", 16'(out_valid), 16'd0);
        chk("ovr_sticky", 16'(ovr_err), 16'd1);
        send(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1);
        check_out("5a_gapped", 1'b1);
        @(posedge clk); #1;
        chk("5a_consumed", 16'(out_valid), 16'd0);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        chk("partial_busy", 16'(busy), 16'd1);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 16'(busy), 16'd0);
        chk("midrst_ovr", 16'(ovr_err), 16'd0);
        chk("midrst_data", 16'(out_data), 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        s_valid = 1'b1;
        s_bit = 1'b1;
        @(posedge clk); #1;
        chk("idle_ignores_1", 16'(busy), 16'd0);
        send(8'h81, 1'b0, 1'b1, 1'b0, 1'b1);
        check_out("81_after_rst", 1'b1);
        chk("81_no_ovr", 16'(ovr_err), 16'd0);
        chk("sb_drained", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
